// File: rtl/radiant_coinc_trigger.sv
// Coincidence trigger: per-channel oneshots, registered popcount, holdoff-gated pulse.
// Optional macro RADIANT_TRIG_COUNT_EN adds the saturating trig_count_o output.
module radiant_coinc_trigger #(
    parameter int NCHAN     = 24,
    parameter int WIN_BITS  = 16,
    parameter int HOLD_BITS = 16,
    parameter int THR_BITS  = 6
) (
    input  logic                 trig_clk_i,
    input  logic                 rst_n_i,
    input  logic [NCHAN-1:0]     trig_i,
    input  logic [NCHAN-1:0]     en_i,
    input  logic [WIN_BITS-1:0]  window_i,
    input  logic [THR_BITS-1:0]  threshold_i,
    input  logic [HOLD_BITS-1:0] holdoff_i,
    input  logic                 retrig_i,
    input  logic                 cfg_load_i,
`ifdef RADIANT_TRIG_COUNT_EN
    output logic [31:0]          trig_count_o,
`endif
    output logic                 trigger_o,
    output logic [NCHAN-1:0]     active_o
);

    localparam int unsigned NCH  = NCHAN;
    localparam int unsigned GRP  = 8;
    localparam int unsigned NGRP = (NCH + GRP - 1) / GRP;

    // captured configuration
    logic [NCHAN-1:0]     en_q, en_d;
    logic [WIN_BITS-1:0]  win_q, win_d;
    logic [THR_BITS-1:0]  thr_q, thr_d;
    logic [HOLD_BITS-1:0] hold_cfg_q, hold_cfg_d;
    logic                 retrig_q, retrig_d;
    logic                 load_q, load_d;

    // edge detection and oneshots
    logic [NCHAN-1:0]     trig_q, trig_d;
    logic [NCHAN-1:0]     prev_q, prev_d;
    logic [NCHAN-1:0]     rise;
    logic [NCHAN-1:0]     act_q, act_d;
    logic [WIN_BITS-1:0]  cnt_q [NCHAN];
    logic [WIN_BITS-1:0]  cnt_d [NCHAN];

    // popcount pipeline and trigger
    logic [NGRP*GRP-1:0]  act_pad;
    logic [THR_BITS-1:0]  psum_q [NGRP];
    logic [THR_BITS-1:0]  psum_d [NGRP];
    logic [THR_BITS-1:0]  count;
    logic [HOLD_BITS-1:0] hold_q, hold_d;
    logic                 trigger_q, trigger_d;

`ifdef RADIANT_TRIG_COUNT_EN
    logic [31:0]          trig_count_q, trig_count_d;
`endif

    always_ff @(posedge trig_clk_i) begin
        if (!rst_n_i) begin
            en_q       <= '0;
            win_q      <= '0;
            thr_q      <= '0;
            hold_cfg_q <= '0;
            retrig_q   <= 1'b0;
            load_q     <= 1'b0;
            trig_q     <= '0;
            prev_q     <= '0;
            act_q      <= '0;
            cnt_q      <= '{default: '0};
            psum_q     <= '{default: '0};
            hold_q     <= '0;
            trigger_q  <= 1'b0;
        end else begin
            en_q       <= en_d;
            win_q      <= win_d;
            thr_q      <= thr_d;
            hold_cfg_q <= hold_cfg_d;
            retrig_q   <= retrig_d;
            load_q     <= load_d;
            trig_q     <= trig_d;
            prev_q     <= prev_d;
            act_q      <= act_d;
            cnt_q      <= cnt_d;
            psum_q     <= psum_d;
            hold_q     <= hold_d;
            trigger_q  <= trigger_d;
        end
    end

    always_comb begin
        en_d       = en_q;
        win_d      = win_q;
        thr_d      = thr_q;
        hold_cfg_d = hold_cfg_q;
        retrig_d   = retrig_q;
        load_d     = cfg_load_i;
        if (cfg_load_i) begin
            en_d       = en_i;
            win_d      = window_i;
            thr_d      = threshold_i;
            hold_cfg_d = holdoff_i;
            retrig_d   = retrig_i;
        end
    end

    // Edges sampled in the load cycle are dropped; history keeps tracking so
    // a level held across the load does not look like a fresh edge.
    always_comb begin
        trig_d = trig_i;
        prev_d = trig_q;
        rise   = trig_q & ~prev_q & en_q & ~{NCHAN{load_q}};
    end

    // A oneshot in its last cycle accepts a new start, so back-to-back windows have no gap.
    always_comb begin
        act_d = act_q;
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (rise[i] && (retrig_q || !act_q[i] || (cnt_q[i] == '0))) begin
                act_d[i] = 1'b1;
                cnt_d[i] = win_q;
            end else if (act_q[i]) begin
                if (cnt_q[i] == '0) begin
                    act_d[i] = 1'b0;
                end else begin
                    cnt_d[i] = cnt_q[i] - WIN_BITS'(1);
                end
            end
        end
        if (cfg_load_i) begin
            act_d = '0;
            cnt_d = '{default: '0};
        end
    end

    always_comb begin
        act_pad            = '0;
        act_pad[NCHAN-1:0] = act_q;
        for (int unsigned g = 0; g < NGRP; g++) begin
            psum_d[g] = '0;
            for (int unsigned j = 0; j < GRP; j++) begin
                psum_d[g] = psum_d[g] + THR_BITS'(act_pad[g*GRP + j]);
            end
            if (cfg_load_i) begin
                psum_d[g] = '0;
            end
        end
    end

    // Second adder stage is folded into the compare feeding the trigger register.
    always_comb begin
        count = '0;
        for (int unsigned g = 0; g < NGRP; g++) begin
            count = count + psum_q[g];
        end
        trigger_d = !cfg_load_i && (thr_q != '0) && (count >= thr_q) && (hold_q == '0);
        if (cfg_load_i) begin
            hold_d = '0;
        end else if (trigger_d) begin
            hold_d = hold_cfg_q;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_BITS'(1);
        end else begin
            hold_d = hold_q;
        end
    end

`ifdef RADIANT_TRIG_COUNT_EN
    always_ff @(posedge trig_clk_i) begin
        if (!rst_n_i) begin
            trig_count_q <= '0;
        end else begin
            trig_count_q <= trig_count_d;
        end
    end

    always_comb begin
        trig_count_d = trig_count_q;
        if (cfg_load_i) begin
            trig_count_d = '0;
        end else if (trigger_d && (trig_count_q != '1)) begin
            trig_count_d = trig_count_q + 32'd1;
        end
    end

    assign trig_count_o = trig_count_q;
`endif

    assign trigger_o = trigger_q;
    assign active_o  = act_q;

endmodule

// File: tb/tb_radiant_coinc_trigger.sv
// Randomized and directed bench for radiant_coinc_trigger against an
// interval-based reference model; covers trig_count_o when RADIANT_TRIG_COUNT_EN is set.
`timescale 1ns/1ps
module tb_radiant_coinc_trigger;

    localparam int NCHAN     = 24;
    localparam int WIN_BITS  = 16;
    localparam int HOLD_BITS = 16;
    localparam int THR_BITS  = 6;
    localparam int NEVER     = 1 << 30;

    logic                 trig_clk_i = 1'b0;
    logic                 rst_n_i;
    logic [NCHAN-1:0]     trig_i;
    logic [NCHAN-1:0]     en_i;
    logic [WIN_BITS-1:0]  window_i;
    logic [THR_BITS-1:0]  threshold_i;
    logic [HOLD_BITS-1:0] holdoff_i;
    logic                 retrig_i;
    logic                 cfg_load_i;
    logic                 trigger_o;
    logic [NCHAN-1:0]     active_o;
`ifdef RADIANT_TRIG_COUNT_EN
    logic [31:0]          trig_count_o;
`endif

    radiant_coinc_trigger #(
        .NCHAN(NCHAN),
        .WIN_BITS(WIN_BITS),
        .HOLD_BITS(HOLD_BITS),
        .THR_BITS(THR_BITS)
    ) dut (
        .trig_clk_i(trig_clk_i),
        .rst_n_i(rst_n_i),
        .trig_i(trig_i),
        .en_i(en_i),
        .window_i(window_i),
        .threshold_i(threshold_i),
        .holdoff_i(holdoff_i),
        .retrig_i(retrig_i),
        .cfg_load_i(cfg_load_i),
`ifdef RADIANT_TRIG_COUNT_EN
        .trig_count_o(trig_count_o),
`endif
        .trigger_o(trigger_o),
        .active_o(active_o)
    );

    always #5 trig_clk_i = ~trig_clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: each channel is an active interval [start, end] in cycle numbers.
    int               m_start [NCHAN];
    int               m_end   [NCHAN];
    bit               m_hist  [NCHAN];
    bit               m_det   [NCHAN];
    logic [NCHAN-1:0] m_en;
    int               m_w, m_t, m_h;
    bit               m_r;
    int               m_pipe;
    int               m_next_ok;
    bit               m_trig;
    logic [NCHAN-1:0] m_act;
    longint           m_cnt;
    int               cyc;
    int               pulses[$];
    int               s0;
    int               first;
    logic [NCHAN-1:0] cur;

    task automatic clear_intervals();
        for (int i = 0; i < NCHAN; i++) begin
            m_start[i] = NEVER;
            m_end[i]   = -1;
        end
    endtask

    task automatic step(input logic [NCHAN-1:0] tv, input bit ld, input bit rst);
        int c;
        int cnt_now;
        bit alive;
        trig_i     = tv;
        cfg_load_i = ld;
        rst_n_i    = !rst;
        if (!ld) begin
            en_i        = NCHAN'($urandom);
            window_i    = WIN_BITS'($urandom);
            threshold_i = THR_BITS'($urandom);
            holdoff_i   = HOLD_BITS'($urandom);
            retrig_i    = 1'($urandom);
        end
        c       = cyc;
        cnt_now = $countones(m_act);
        if (rst) begin
            clear_intervals();
            for (int i = 0; i < NCHAN; i++) begin
                m_hist[i] = 1'b0;
                m_det[i]  = 1'b0;
            end
            m_en = '0; m_w = 0; m_t = 0; m_h = 0; m_r = 1'b0;
            m_trig = 1'b0; m_pipe = 0; m_next_ok = 0; m_cnt = 0;
        end else begin
            if (ld) begin
                m_trig = 1'b0; m_pipe = 0; m_next_ok = 0;
            end else begin
                m_trig = (m_t != 0) && (m_pipe >= m_t) && (c + 1 >= m_next_ok);
                if (m_trig) begin
                    m_next_ok = c + 2 + m_h;
                    if (m_cnt != 64'hFFFF_FFFF) m_cnt++;
                end
                m_pipe = cnt_now;
            end
            for (int i = 0; i < NCHAN; i++) begin
                if (m_det[i] && m_en[i]) begin
                    alive = (m_start[i] <= c) && (c <= m_end[i]);
                    if (m_r || !alive || (m_end[i] == c)) begin
                        m_start[i] = c + 1;
                        m_end[i]   = c + 1 + m_w;
                    end
                end
            end
            for (int i = 0; i < NCHAN; i++) begin
                m_det[i]  = tv[i] && !m_hist[i] && !ld;
                m_hist[i] = tv[i];
            end
            if (ld) begin
                m_en = en_i; m_w = int'(window_i); m_t = int'(threshold_i);
                m_h = int'(holdoff_i); m_r = retrig_i; m_cnt = 0;
                clear_intervals();
            end
        end
        @(posedge trig_clk_i);
        #1;
        cyc++;
        for (int i = 0; i < NCHAN; i++) m_act[i] = (m_start[i] <= cyc) && (cyc <= m_end[i]);
        check("active_o", 64'(active_o), 64'(m_act));
        check("trigger_o", 64'(trigger_o), 64'(m_trig));
`ifdef RADIANT_TRIG_COUNT_EN
        check("trig_count_o", 64'(trig_count_o), 64'(m_cnt));
`endif
        if (trigger_o === 1'b1) pulses.push_back(cyc);
    endtask

    task automatic load(input logic [NCHAN-1:0] e, input int w, input int t, input int h, input bit r);
        en_i        = e;
        window_i    = WIN_BITS'(w);
        threshold_i = THR_BITS'(t);
        holdoff_i   = HOLD_BITS'(h);
        retrig_i    = r;
        step('0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        pulses.delete();
        s0 = cyc;
    endtask

    function automatic logic [NCHAN-1:0] bit_at(input int ch);
        logic [NCHAN-1:0] v;
        v = '0;
        v[ch] = 1'b1;
        return v;
    endfunction

    function automatic int first_rel();
        return (pulses.size() > 0) ? pulses[0] - s0 : -1;
    endfunction

    initial begin
        cyc = 0;
        m_act = '0;
        clear_intervals();
        for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b1);
        check("reset_active", 64'(active_o), 64'd0);
        check("reset_trigger", 64'(trigger_o), 64'd0);

        // Three staggered edges inside one window
        load('1, 7, 3, 0, 1'b0);
        for (int k = 0; k < 20; k++)
            step((k == 0) ? bit_at(0) : (k == 3) ? bit_at(5) : (k == 6) ? bit_at(9) : '0, 1'b0, 1'b0);
        first = first_rel();
        check("r033_first_pulse", 64'(first), 64'd10);

        // Second edge arrives after the first window expired
        load('1, 7, 2, 0, 1'b0);
        for (int k = 0; k < 20; k++)
            step((k == 0) ? bit_at(0) : (k == 9) ? bit_at(1) : '0, 1'b0, 1'b0);
        check("r034_npulse", 64'(pulses.size()), 64'd0);

        // Retriggerable oneshot stretched by repeated edges
        load('1, 4, 2, 0, 1'b1);
        for (int k = 0; k < 20; k++)
            step((k == 0 || k == 3 || k == 6) ? bit_at(2) : (k == 9) ? bit_at(3) : '0, 1'b0, 1'b0);
        first = first_rel();
        check("r035_first_pulse", 64'(first), 64'd13);

        // Holdoff spacing with sustained coincidence
        load('1, 7, 2, 20, 1'b1);
        for (int k = 0; k < 90; k++)
            step((k % 5 == 0) ? NCHAN'(4'hF) : '0, 1'b0, 1'b0);
        check("r036_npulse_ge3", 64'(pulses.size() >= 3), 64'd1);
        for (int j = 1; j < pulses.size(); j++)
            check("r036_gap", 64'(pulses[j] - pulses[j-1]), 64'd21);

        // Reset in the middle of a pending coincidence
        load('1, 7, 2, 0, 1'b0);
        step(NCHAN'(2'b11), 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b1);
        check("r037_active_after_rst", 64'(active_o), 64'd0);
        for (int k = 0; k < 8; k++) step('0, 1'b0, 1'b0);
        check("r037_npulse", 64'(pulses.size()), 64'd0);

        // Load coincident with reset must not apply
        en_i = '1; window_i = 16'd7; threshold_i = 6'd1; holdoff_i = '0; retrig_i = 1'b0;
        step('0, 1'b1, 1'b1);
        pulses.delete();
        for (int k = 0; k < 10; k++) step((k % 2 == 0) ? '1 : '0, 1'b0, 1'b0);
        check("r030_npulse", 64'(pulses.size()), 64'd0);

`ifdef RADIANT_TRIG_COUNT_EN
        load('1, 7, 3, 0, 1'b0);
        force dut.trig_count_q = 32'hFFFF_FFFE;
        m_cnt = 64'hFFFF_FFFE;
        step('0, 1'b0, 1'b0);
        release dut.trig_count_q;
        for (int rep = 0; rep < 2; rep++)
            for (int k = 0; k < 20; k++)
                step((k == 0) ? bit_at(0) : (k == 3) ? bit_at(5) : (k == 6) ? bit_at(9) : '0, 1'b0, 1'b0);
        check("r038_saturated", 64'(trig_count_o), 64'hFFFF_FFFF);
        load('1, 7, 3, 0, 1'b0);
        check("r038_cleared", 64'(trig_count_o), 64'd0);
`endif

        // Randomized configurations and traffic
        for (int r = 0; r < 6; r++) begin
            load(NCHAN'($urandom) | NCHAN'($urandom), $urandom_range(0, 6),
                 $urandom_range(0, 5), $urandom_range(0, 10), 1'($urandom));
            cur = '0;
            for (int k = 0; k < 150; k++) begin
                bit ld;
                bit rst;
                cur = cur ^ (NCHAN'($urandom) & NCHAN'($urandom) & NCHAN'($urandom));
                ld  = ($urandom_range(0, 59) == 0);
                rst = ($urandom_range(0, 299) == 0);
                if (ld) begin
                    en_i        = NCHAN'($urandom) | NCHAN'($urandom);
                    window_i    = WIN_BITS'($urandom_range(0, 6));
                    threshold_i = THR_BITS'($urandom_range(0, 5));
                    holdoff_i   = HOLD_BITS'($urandom_range(0, 10));
                    retrig_i    = 1'($urandom);
                end
                step(cur, ld, rst);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
